// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS program loader / run sequencer.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    HALT,
    ERR
  } boot_state_e;

  typedef enum logic [1:0] {
    MUX_IDLE,
    MUX_LOAD,
    MUX_CORE
  } mux_sel_e;

  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_FFFC;
  localparam logic [31:0] BOOT_WORD_BYTES   = 32'd4;

  // Byte address of the idx-th word of the load window.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + ({16'd0, idx} * BOOT_WORD_BYTES);
  endfunction

endpackage

// File: rtl/boot_mem_mux.sv
// Memory port select between idle, loader and core; a core store to the halt
// address is reported and kept off the memory.
module boot_mem_mux
  import mips_boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] HALT_ADDR = DEFAULT_HALT_ADDR
) (
  input  mux_sel_e    sel,
  input  logic [31:0] ld_adr,
  input  logic [31:0] ld_data,
  input  logic [31:0] core_adr,
  input  logic [31:0] core_writedata,
  input  logic        core_memwrite,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_writedata,
  output logic        mem_memwrite,
  output logic        halt_hit
);

  always_comb begin
    mem_adr       = BASE_ADDR;
    mem_writedata = '0;
    mem_memwrite  = 1'b0;
    halt_hit      = 1'b0;
    case (sel)
      MUX_LOAD: begin
        mem_adr       = ld_adr;
        mem_writedata = ld_data;
        mem_memwrite  = 1'b1;
      end
      MUX_CORE: begin
        halt_hit      = core_memwrite && (core_adr == HALT_ADDR);
        mem_adr       = core_adr;
        mem_writedata = core_writedata;
        mem_memwrite  = core_memwrite && !halt_hit;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_boot_ctrl.sv
// Program loader and run sequencer for the multi-cycle MIPS core.
// Optional cycle counter enabled by defining MIPS_BOOT_CYCLE_CNT_EN.
module mips_boot_ctrl
  import mips_boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] HALT_ADDR = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        core_reset_n,
  input  logic [31:0] core_adr,
  input  logic [31:0] core_writedata,
  input  logic        core_memwrite,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_writedata,
  output logic        mem_memwrite,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words,
  output logic [31:0] cycles
);

  localparam logic [15:0] MAX_W  = 16'(MAX_WORDS);
  localparam logic [15:0] LAST_W = 16'(MAX_WORDS - 1);

  boot_state_e state_reg, state_next;
  logic [15:0] words_reg, words_next;
  logic        core_reset_n_reg;
  logic        ld_fire;
  logic        halt_hit;
  mux_sel_e    mux_sel;

  assign ld_ready = reset_n && (state_reg == LOAD) && (words_reg < MAX_W);
  assign ld_fire  = ld_valid && ld_ready;

  // Port ownership is decided outside the FSM process so halt_hit feeds back cleanly.
  assign mux_sel = !reset_n              ? MUX_IDLE :
                   (state_reg == RUN)    ? MUX_CORE :
                   ld_fire               ? MUX_LOAD : MUX_IDLE;

  boot_mem_mux #(
    .BASE_ADDR(BASE_ADDR),
    .HALT_ADDR(HALT_ADDR)
  ) u_mux (
    .sel           (mux_sel),
    .ld_adr        (word_addr(BASE_ADDR, words_reg)),
    .ld_data       (ld_data),
    .core_adr      (core_adr),
    .core_writedata(core_writedata),
    .core_memwrite (core_memwrite),
    .mem_adr       (mem_adr),
    .mem_writedata (mem_writedata),
    .mem_memwrite  (mem_memwrite),
    .halt_hit      (halt_hit)
  );

  always_comb begin
    state_next = state_reg;
    words_next = words_reg;
    case (state_reg)
      IDLE, HALT, ERR: begin
        if (start) begin
          state_next = LOAD;
          words_next = '0;
        end
      end
      LOAD: begin
        if (ld_fire) begin
          words_next = words_reg + 16'd1;
          if (ld_last)
            state_next = RUN;
          else if (words_reg == LAST_W)
            state_next = ERR;
        end else if (words_reg >= MAX_W) begin
          state_next = ERR;
        end
      end
      RUN: begin
        if (halt_hit)
          state_next = HALT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      words_reg        <= '0;
      core_reset_n_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      words_reg        <= words_next;
      core_reset_n_reg <= (state_next == RUN);
    end
  end

`ifdef MIPS_BOOT_CYCLE_CNT_EN
  logic [31:0] cycles_reg;
  logic        clear_counts;

  assign clear_counts = start && ((state_reg == IDLE) || (state_reg == HALT) || (state_reg == ERR));

  // Counts cycles the core actually sees out of reset; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n || clear_counts)
      cycles_reg <= '0;
    else if (core_reset_n_reg && (cycles_reg != 32'hFFFF_FFFF))
      cycles_reg <= cycles_reg + 32'd1;
  end

  assign cycles = cycles_reg;
`else
  assign cycles = 32'h0;
`endif

  assign core_reset_n = core_reset_n_reg;
  assign words        = words_reg;
  assign busy         = (state_reg == LOAD) || (state_reg == RUN);
  assign done         = (state_reg == HALT);
  assign err          = (state_reg == ERR);

endmodule
